// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_rd_ctrl: read-domain controller for the bridge async FIFO. Tracks the |
// | read pointer, sequences RAM reads and holds words in a valid/ready slot.   |
// | Optional: define FIFO_RD_FLUSH_EN to add the synchronous flush input.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fifo_rd_ctrl #(
  parameter int WIDTH    = 32,
  parameter int ADDRBITS = 4
) (
  input  logic                r_clk,
  input  logic                reset,
`ifdef FIFO_RD_FLUSH_EN
  input  logic                flush,
`endif
  input  logic [ADDRBITS:0]   w_syn,
  output logic [ADDRBITS:0]   rgrey,
  output logic [ADDRBITS-1:0] raddr,
  output logic                ren,
  input  logic [WIDTH-1:0]    rdata_mem,
  output logic [WIDTH-1:0]    rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                empty,
  output logic [ADDRBITS:0]   rlevel
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_fetch = 2'd1;
  localparam logic [1:0] c_valid = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [ADDRBITS:0]  r_rbin;
  logic [ADDRBITS:0]  r_rgrey;
  logic [ADDRBITS:0]  w_rbin_next;
  logic [ADDRBITS:0]  w_wbin;
  logic [WIDTH-1:0]   r_rd_data;
  logic               r_rd_valid;
  logic               w_ren;
  logic               w_flush;
  logic               w_empty;

  function automatic logic [ADDRBITS:0] gray2bin(input logic [ADDRBITS:0] g);
    logic [ADDRBITS:0] b;
    b[ADDRBITS] = g[ADDRBITS];
    for (int i = ADDRBITS - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

`ifdef FIFO_RD_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_wbin      = gray2bin(w_syn);
  assign w_empty     = (r_rgrey == w_syn);
  assign w_rbin_next = r_rbin + {{ADDRBITS{1'b0}}, w_ren};

  // State register
  always_ff @(posedge r_clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flush overrides any handshake in progress
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:  if (w_ren) w_state_next = c_fetch;
      c_fetch: w_state_next = c_valid;
      c_valid: if (rd_ready) w_state_next = w_ren ? c_fetch : c_idle;
      default: w_state_next = c_idle;
    endcase
    if (w_flush) begin
      w_state_next = c_idle;
    end
  end

  // Output logic: RAM read enable, held low during reset and flush
  always_comb begin
    w_ren = 1'b0;
    if (reset && !w_flush) begin
      case (r_state)
        c_idle:  w_ren = !w_empty;
        c_valid: w_ren = rd_ready && !w_empty;
        default: w_ren = 1'b0;
      endcase
    end
  end

  // Pointer and output slot datapath
  always_ff @(posedge r_clk or negedge reset) begin
    if (!reset) begin
      r_rbin     <= '0;
      r_rgrey    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (w_flush) begin
      r_rbin     <= w_wbin;
      r_rgrey    <= w_syn;
      r_rd_valid <= 1'b0;
    end else begin
      r_rbin  <= w_rbin_next;
      r_rgrey <= w_rbin_next ^ (w_rbin_next >> 1);
      if (r_state == c_fetch) begin
        r_rd_data  <= rdata_mem;
        r_rd_valid <= 1'b1;
      end else if (r_state == c_valid && rd_ready) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign ren      = w_ren;
  assign raddr    = r_rbin[ADDRBITS-1:0];
  assign rgrey    = r_rgrey;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign empty    = w_empty;
  assign rlevel   = w_wbin - r_rbin;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo_rd_ctrl: directed self-checking bench for fifo_rd_ctrl with a      |
// | behavioural RAM and write-pointer model. Flush test under FIFO_RD_FLUSH_EN.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fifo_rd_ctrl;
  localparam int WIDTH    = 32;
  localparam int ADDRBITS = 4;

  logic              r_clk = 1'b0;
  logic              reset = 1'b0;
`ifdef FIFO_RD_FLUSH_EN
  logic              flush = 1'b0;
`endif
  logic [4:0]        w_syn = '0;
  logic [4:0]        rgrey;
  logic [3:0]        raddr;
  logic              ren;
  logic [31:0]       rdata_mem = '0;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic              empty;
  logic [4:0]        rlevel;

  logic [31:0]       mem [16];
  logic [4:0]        wptr = '0;
  logic [4:0]        exp_rbin;
  logic [4:0]        lvl;
  int                written = 0;
  int                next_read;
  int                n_checks = 0;
  int                n_errors = 0;
  logic              pend_wrap;
  logic              saw_wrap;

  fifo_rd_ctrl #(.WIDTH(WIDTH), .ADDRBITS(ADDRBITS)) dut (
    .r_clk     (r_clk),
    .reset     (reset),
`ifdef FIFO_RD_FLUSH_EN
    .flush     (flush),
`endif
    .w_syn     (w_syn),
    .rgrey     (rgrey),
    .raddr     (raddr),
    .ren       (ren),
    .rdata_mem (rdata_mem),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .empty     (empty),
    .rlevel    (rlevel)
  );

  always #5 r_clk = ~r_clk;

  // Synchronous-read RAM: data appears the cycle after ren
  always @(posedge r_clk) begin
    if (ren) rdata_mem <= mem[raddr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] dat(input int k);
    return 32'hD000_0000 + k;
  endfunction

  task automatic write_word();
    mem[wptr[3:0]] = dat(written);
    written++;
    wptr = wptr + 5'd1;
    w_syn = gray(wptr);
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset
    tick();
    chk("rst_ren_low", ren, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    chk("rst_rgrey", rgrey, 5'd0);
    chk("rst_raddr", raddr, 4'd0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_rlevel", rlevel, 5'd0);
    chk("rst_ren", ren, 1'b0);

    // First word, consumer ready
    rd_ready = 1'b1;
    write_word();
    #1;
    chk("w0_ren", ren, 1'b1);
    chk("w0_raddr", raddr, 4'd0);
    chk("w0_empty", empty, 1'b0);
    chk("w0_rlevel", rlevel, 5'd1);
    tick();
    chk("w0_fetch_ren", ren, 1'b0);
    chk("w0_rgrey", rgrey, 5'b00001);
    chk("w0_empty_after", empty, 1'b1);
    chk("w0_rlevel_after", rlevel, 5'd0);
    chk("w0_valid_early", rd_valid, 1'b0);
    tick();
    chk("w0_valid", rd_valid, 1'b1);
    chk("w0_data", rd_data, 32'hD000_0000);
    chk("w0_valid_ren", ren, 1'b0);
    tick();
    chk("w0_consumed", rd_valid, 1'b0);

    // Two words, consumer stalled
    rd_ready = 1'b0;
    write_word();
    write_word();
    #1;
    chk("st_ren", ren, 1'b1);
    chk("st_raddr", raddr, 4'd1);
    chk("st_rlevel", rlevel, 5'd2);
    tick();
    chk("st_rgrey", rgrey, 5'b00011);
    chk("st_fetch_ren", ren, 1'b0);
    tick();
    chk("st_valid", rd_valid, 1'b1);
    chk("st_data", rd_data, 32'hD000_0001);
    chk("st_hold_ren", ren, 1'b0);
    chk("st_rlevel1", rlevel, 5'd1);
    tick();
    write_word();
    #1;
    chk("st_wsyn_in_valid_ren", ren, 1'b0);
    chk("st_data_stable", rd_data, 32'hD000_0001);
    chk("st_valid_stable", rd_valid, 1'b1);
    rd_ready = 1'b1;
    #1;
    chk("st_hs_ren", ren, 1'b1);
    chk("st_hs_raddr", raddr, 4'd2);
    tick();
    chk("st_hs_valid_drop", rd_valid, 1'b0);
    tick();
    chk("st_data2", rd_data, 32'hD000_0002);
    chk("st_b2b_ren", ren, 1'b1);
    chk("st_b2b_raddr", raddr, 4'd3);
    tick();
    tick();
    chk("st_data3", rd_data, 32'hD000_0003);
    chk("st_data3_ren", ren, 1'b0);
    tick();
    chk("st_idle_valid", rd_valid, 1'b0);

    // Wrap-around drain against a pointer model
    exp_rbin  = 5'd4;
    next_read = 4;
    pend_wrap = 1'b0;
    saw_wrap  = 1'b0;
    for (int cyc = 0; cyc < 400 && next_read < 20; cyc++) begin
      tick();
      chk("wrap_rgrey", rgrey, gray(exp_rbin));
      if (pend_wrap) begin
        chk("wrap_rgrey_15_16", rgrey, 5'b11000);
        pend_wrap = 1'b0;
        saw_wrap  = 1'b1;
      end
      lvl = wptr - exp_rbin;
      if (written < 20 && lvl < 5'd16 && (cyc % 3) != 2) write_word();
      #1;
      lvl = wptr - exp_rbin;
      chk("wrap_empty", empty, (wptr == exp_rbin));
      chk("wrap_rlevel", rlevel, lvl);
      if (rd_valid) begin
        chk("wrap_data", rd_data, dat(next_read));
        next_read++;
      end
      if (ren) begin
        chk("wrap_raddr", raddr, exp_rbin[3:0]);
        if (exp_rbin == 5'd15) pend_wrap = 1'b1;
        exp_rbin = exp_rbin + 5'd1;
      end
    end
    chk("wrap_drained", next_read, 20);
    chk("wrap_seen", saw_wrap, 1'b1);
    chk("wrap_final_rgrey", rgrey, 5'b11110);

    // Reset asserted during FETCH
    tick();
    write_word();
    #1;
    chk("rf_ren", ren, 1'b1);
    tick();
    reset = 1'b0;
    #1;
    chk("rf_rgrey", rgrey, 5'd0);
    chk("rf_raddr", raddr, 4'd0);
    chk("rf_valid", rd_valid, 1'b0);
    chk("rf_ren_forced", ren, 1'b0);
    tick();
    chk("rf_no_capture", rd_data, 32'd0);
    chk("rf_valid2", rd_valid, 1'b0);
    chk("rf_empty_low", empty, 1'b0);
    chk("rf_ren_in_reset", ren, 1'b0);
    wptr    = '0;
    written = 0;
    w_syn   = '0;
    reset   = 1'b1;
    tick();
    chk("rf_post_ren", ren, 1'b0);
    chk("rf_post_empty", empty, 1'b1);
    chk("rf_post_rlevel", rlevel, 5'd0);
    write_word();
    #1;
    chk("rf_idle_ren", ren, 1'b1);
    chk("rf_idle_raddr", raddr, 4'd0);
    tick();
    tick();
    chk("rf_word0", rd_data, 32'hD000_0000);
    tick();

`ifdef FIFO_RD_FLUSH_EN
    // Flush while a word is held
    rd_ready = 1'b0;
    write_word();
    #1;
    chk("fl_ren", ren, 1'b1);
    tick();
    tick();
    chk("fl_valid", rd_valid, 1'b1);
    chk("fl_data", rd_data, 32'hD000_0001);
    for (int i = 0; i < 7; i++) write_word();
    chk("fl_wsyn", w_syn, 5'b01101);
    rd_ready = 1'b1;
    flush    = 1'b1;
    #1;
    chk("fl_ren_forced", ren, 1'b0);
    tick();
    flush = 1'b0;
    chk("fl_valid_drop", rd_valid, 1'b0);
    chk("fl_rgrey", rgrey, 5'b01101);
    chk("fl_empty", empty, 1'b1);
    chk("fl_rlevel", rlevel, 5'd0);
    chk("fl_ren_after", ren, 1'b0);
    tick();
    chk("fl_valid_after", rd_valid, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
